// File: rtl/noc_pe_interface_if.sv
// Handshake bundle between a PE, its network interface and the HNoC port.
// The slave modport is the network interface's view; master is the surrounding PE/NoC.
interface noc_pe_interface_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 4
);
  localparam int FlitWidth = DataWidth + AddrWidth;

  logic [DataWidth-1:0] i_pe_tx_data;
  logic [AddrWidth-1:0] i_pe_tx_dest;
  logic                 i_pe_tx_valid;
  logic                 o_pe_tx_ready;

  logic [FlitWidth-1:0] o_noc_data;
  logic                 o_noc_valid;
  logic                 i_noc_ready;

  logic [FlitWidth-1:0] i_noc_data;
  logic                 i_noc_valid;
  logic                 o_noc_ready;

  logic [DataWidth-1:0] o_pe_rx_data;
  logic                 o_pe_rx_valid;
  logic                 i_pe_rx_ready;

  logic                 o_err_self;
  logic                 o_err_misroute;

  modport slave (
    input  i_pe_tx_data, i_pe_tx_dest, i_pe_tx_valid, i_noc_ready,
    input  i_noc_data, i_noc_valid, i_pe_rx_ready,
    output o_pe_tx_ready, o_noc_data, o_noc_valid, o_noc_ready,
    output o_pe_rx_data, o_pe_rx_valid, o_err_self, o_err_misroute
  );

  modport master (
    output i_pe_tx_data, i_pe_tx_dest, i_pe_tx_valid, i_noc_ready,
    output i_noc_data, i_noc_valid, i_pe_rx_ready,
    input  o_pe_tx_ready, o_noc_data, o_noc_valid, o_noc_ready,
    input  o_pe_rx_data, o_pe_rx_valid, o_err_self, o_err_misroute
  );
endinterface

// File: rtl/noc_pe_interface.sv
// Per-PE network interface: packs/filters flits through TX and RX FIFOs.
// Define NI_STATS_EN to add the 16-bit o_tx_count / o_rx_count traffic counters.
module NiFifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [Width-1:0] i_wr_data,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [Width-1:0] o_rd_data
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_wr;
  logic             w_rd;

  // Flags come only from the registered count, so ready never depends on the reader.
  assign o_wr_ready = (r_count != CntW'(Depth));
  assign o_rd_valid = (r_count != '0);
  assign o_rd_data  = r_mem[r_rd_ptr];
  assign w_wr       = i_wr_valid && o_wr_ready;
  assign w_rd       = o_rd_valid && i_rd_ready;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module noc_pe_interface #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 4,
  parameter int FifoDepth = 4,
  parameter int PeId      = 0
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  noc_pe_interface_if.slave      ni
`ifdef NI_STATS_EN
  ,
  output logic [15:0]            o_tx_count,
  output logic [15:0]            o_rx_count
`endif
);
  localparam int                   FlitWidth = DataWidth + AddrWidth;
  localparam logic [AddrWidth-1:0] LpPeId    = AddrWidth'(PeId);

  logic                 w_tx_fwd;
  logic                 w_tx_self;
  logic [AddrWidth-1:0] w_rx_addr;
  logic                 w_rx_accept;
  logic                 w_rx_local;
  logic                 r_err_self;
  logic                 r_err_misroute;

  // Self-addressed packets still complete the PE handshake but never enter the FIFO.
  assign w_tx_fwd  = ni.i_pe_tx_valid && (ni.i_pe_tx_dest != LpPeId);
  assign w_tx_self = ni.i_pe_tx_valid && ni.o_pe_tx_ready && (ni.i_pe_tx_dest == LpPeId);

  NiFifo #(.Width(FlitWidth), .Depth(FifoDepth)) u_tx_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wr_valid (w_tx_fwd),
    .o_wr_ready (ni.o_pe_tx_ready),
    .i_wr_data  ({ni.i_pe_tx_dest, ni.i_pe_tx_data}),
    .o_rd_valid (ni.o_noc_valid),
    .i_rd_ready (ni.i_noc_ready),
    .o_rd_data  (ni.o_noc_data)
  );

  assign w_rx_addr   = ni.i_noc_data[FlitWidth-1 -: AddrWidth];
  assign w_rx_local  = ni.i_noc_valid && (w_rx_addr == LpPeId);
  assign w_rx_accept = ni.i_noc_valid && ni.o_noc_ready;

  NiFifo #(.Width(DataWidth), .Depth(FifoDepth)) u_rx_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wr_valid (w_rx_local),
    .o_wr_ready (ni.o_noc_ready),
    .i_wr_data  (ni.i_noc_data[DataWidth-1:0]),
    .o_rd_valid (ni.o_pe_rx_valid),
    .i_rd_ready (ni.i_pe_rx_ready),
    .o_rd_data  (ni.o_pe_rx_data)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_err_self     <= 1'b0;
      r_err_misroute <= 1'b0;
    end else begin
      if (w_tx_self) r_err_self <= 1'b1;
      if (w_rx_accept && (w_rx_addr != LpPeId)) r_err_misroute <= 1'b1;
    end
  end

  assign ni.o_err_self     = r_err_self;
  assign ni.o_err_misroute = r_err_misroute;

`ifdef NI_STATS_EN
  logic [15:0] r_tx_count;
  logic [15:0] r_rx_count;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_tx_count <= '0;
      r_rx_count <= '0;
    end else begin
      if (ni.o_noc_valid && ni.i_noc_ready)      r_tx_count <= r_tx_count + 16'd1;
      if (ni.o_pe_rx_valid && ni.i_pe_rx_ready)  r_rx_count <= r_rx_count + 16'd1;
    end
  end

  assign o_tx_count = r_tx_count;
  assign o_rx_count = r_rx_count;
`endif
endmodule

// File: tb/tb_noc_pe_interface.sv
// Directed self-checking bench for noc_pe_interface (PeId=2, FifoDepth=4).
module tb_noc_pe_interface;
  localparam int DataWidth = 32;
  localparam int AddrWidth = 4;
  localparam int FifoDepth = 4;
  localparam int PeId      = 2;

  logic i_clk;
  logic i_reset;
  int   testsRun;
  int   testsFailed;

  noc_pe_interface_if #(.DataWidth(DataWidth), .AddrWidth(AddrWidth)) ni ();

`ifdef NI_STATS_EN
  logic [15:0] txCount;
  logic [15:0] rxCount;
`endif

  noc_pe_interface #(
    .DataWidth (DataWidth),
    .AddrWidth (AddrWidth),
    .FifoDepth (FifoDepth),
    .PeId      (PeId)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .ni      (ni.slave)
`ifdef NI_STATS_EN
    ,
    .o_tx_count (txCount),
    .o_rx_count (rxCount)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Advance one active edge and settle just after it, where inputs are driven and outputs sampled.
  task automatic applyStimulus();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    i_reset = 1'b0;
    ni.i_pe_tx_data  = '0;
    ni.i_pe_tx_dest  = '0;
    ni.i_pe_tx_valid = 1'b0;
    ni.i_noc_ready   = 1'b0;
    ni.i_noc_data    = '0;
    ni.i_noc_valid   = 1'b0;
    ni.i_pe_rx_ready = 1'b0;

    #3;
    checkOutput("rst_noc_valid", 64'(ni.o_noc_valid), 64'd0);
    checkOutput("rst_rx_valid", 64'(ni.o_pe_rx_valid), 64'd0);
    checkOutput("rst_tx_ready", 64'(ni.o_pe_tx_ready), 64'd1);
    checkOutput("rst_noc_ready", 64'(ni.o_noc_ready), 64'd1);
    checkOutput("rst_err_self", 64'(ni.o_err_self), 64'd0);
    checkOutput("rst_err_mis", 64'(ni.o_err_misroute), 64'd0);
    @(negedge i_clk);
    i_reset = 1'b1;
    applyStimulus();

    // Single TX to PE 5
    ni.i_noc_ready   = 1'b1;
    ni.i_pe_tx_valid = 1'b1;
    ni.i_pe_tx_dest  = 4'd5;
    ni.i_pe_tx_data  = 32'hDEADBEEF;
    checkOutput("tx1_ready", 64'(ni.o_pe_tx_ready), 64'd1);
    checkOutput("tx1_pre_valid", 64'(ni.o_noc_valid), 64'd0);
    applyStimulus();
    ni.i_pe_tx_valid = 1'b0;
    checkOutput("tx1_valid", 64'(ni.o_noc_valid), 64'd1);
    checkOutput("tx1_data", 64'(ni.o_noc_data), 64'h5DEADBEEF);
    applyStimulus();
    checkOutput("tx1_drained", 64'(ni.o_noc_valid), 64'd0);

    // TX backpressure: four fit, fifth waits for the first drain
    ni.i_noc_ready  = 1'b0;
    ni.i_pe_tx_dest = 4'd1;
    for (int i = 0; i < 4; i++) begin
      ni.i_pe_tx_valid = 1'b1;
      ni.i_pe_tx_data  = 32'h100 + 32'(i);
      checkOutput($sformatf("bp_ready%0d", i), 64'(ni.o_pe_tx_ready), 64'd1);
      applyStimulus();
    end
    ni.i_pe_tx_data = 32'h104;
    checkOutput("bp_full_ready", 64'(ni.o_pe_tx_ready), 64'd0);
    checkOutput("bp_head", 64'(ni.o_noc_data), 64'h100000100);
    ni.i_noc_ready = 1'b1;
    applyStimulus();
    checkOutput("bp_ready_back", 64'(ni.o_pe_tx_ready), 64'd1);
    checkOutput("bp_data1", 64'(ni.o_noc_data), 64'h100000101);
    applyStimulus();
    ni.i_pe_tx_valid = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      checkOutput($sformatf("bp_valid%0d", i), 64'(ni.o_noc_valid), 64'd1);
      checkOutput($sformatf("bp_data%0d", i), 64'(ni.o_noc_data), 64'h100000100 + 64'(i));
      applyStimulus();
    end
    checkOutput("bp_empty", 64'(ni.o_noc_valid), 64'd0);

    // Self-addressed packet is swallowed and flagged
    ni.i_pe_tx_valid = 1'b1;
    ni.i_pe_tx_dest  = 4'(PeId);
    ni.i_pe_tx_data  = 32'h12345678;
    checkOutput("self_ready", 64'(ni.o_pe_tx_ready), 64'd1);
    applyStimulus();
    ni.i_pe_tx_valid = 1'b0;
    checkOutput("self_no_valid", 64'(ni.o_noc_valid), 64'd0);
    checkOutput("self_err", 64'(ni.o_err_self), 64'd1);
    applyStimulus();
    applyStimulus();
    checkOutput("self_err_held", 64'(ni.o_err_self), 64'd1);
    checkOutput("self_still_idle", 64'(ni.o_noc_valid), 64'd0);

    // RX filter: local flit kept, foreign flit dropped
    ni.i_pe_rx_ready = 1'b0;
    ni.i_noc_valid   = 1'b1;
    ni.i_noc_data    = 36'h2000000AA;
    applyStimulus();
    ni.i_noc_data    = 36'h7000000BB;
    applyStimulus();
    ni.i_noc_valid   = 1'b0;
    checkOutput("rx_valid", 64'(ni.o_pe_rx_valid), 64'd1);
    checkOutput("rx_data", 64'(ni.o_pe_rx_data), 64'hAA);
    checkOutput("rx_err_mis", 64'(ni.o_err_misroute), 64'd1);
    ni.i_pe_rx_ready = 1'b1;
    applyStimulus();
    ni.i_pe_rx_ready = 1'b0;
    checkOutput("rx_dropped", 64'(ni.o_pe_rx_valid), 64'd0);

    // RX full, then a one-cycle read while a new flit is held
    ni.i_noc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ni.i_noc_data = 36'h2000000C0 + 36'(i);
      applyStimulus();
    end
    ni.i_noc_data = 36'h2000000C4;
    checkOutput("rxf_full", 64'(ni.o_noc_ready), 64'd0);
    ni.i_pe_rx_ready = 1'b1;
    applyStimulus();
    ni.i_pe_rx_ready = 1'b0;
    checkOutput("rxf_ready_back", 64'(ni.o_noc_ready), 64'd1);
    checkOutput("rxf_head", 64'(ni.o_pe_rx_data), 64'hC1);
    applyStimulus();
    ni.i_noc_valid = 1'b0;
    checkOutput("rxf_full_again", 64'(ni.o_noc_ready), 64'd0);
    ni.i_pe_rx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("rxf_valid%0d", i), 64'(ni.o_pe_rx_valid), 64'd1);
      checkOutput($sformatf("rxf_data%0d", i), 64'(ni.o_pe_rx_data), 64'hC0 + 64'(i));
      applyStimulus();
    end
    checkOutput("rxf_empty", 64'(ni.o_pe_rx_valid), 64'd0);
    ni.i_pe_rx_ready = 1'b0;

    // Async reset with two flits buffered in each direction
    ni.i_noc_ready   = 1'b0;
    ni.i_pe_tx_valid = 1'b1;
    ni.i_pe_tx_dest  = 4'd9;
    ni.i_noc_valid   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ni.i_pe_tx_data = 32'hA0 + 32'(i);
      ni.i_noc_data   = 36'h2000000D0 + 36'(i);
      applyStimulus();
    end
    ni.i_pe_tx_valid = 1'b0;
    ni.i_noc_valid   = 1'b0;
    checkOutput("ar_pre_tx", 64'(ni.o_noc_valid), 64'd1);
    checkOutput("ar_pre_rx", 64'(ni.o_pe_rx_valid), 64'd1);
    #2;
    i_reset = 1'b0;
    #1;
    checkOutput("ar_noc_valid", 64'(ni.o_noc_valid), 64'd0);
    checkOutput("ar_rx_valid", 64'(ni.o_pe_rx_valid), 64'd0);
    checkOutput("ar_tx_ready", 64'(ni.o_pe_tx_ready), 64'd1);
    checkOutput("ar_noc_ready", 64'(ni.o_noc_ready), 64'd1);
    checkOutput("ar_err_self", 64'(ni.o_err_self), 64'd0);
    checkOutput("ar_err_mis", 64'(ni.o_err_misroute), 64'd0);
    @(negedge i_clk);
    i_reset          = 1'b1;
    ni.i_noc_ready   = 1'b1;
    ni.i_pe_rx_ready = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("ar_no_stale_tx", 64'(ni.o_noc_valid), 64'd0);
    checkOutput("ar_no_stale_rx", 64'(ni.o_pe_rx_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
